cdu_req_arbiter: RTL and testbench

Shares one compression/decompression unit (CDU) between two requesters (port 0, port 1) using round-robin arbitration. Accepts one request at a time and issues it to the CDU as a single-cycle command. Waits for the CDU response, with a timeout, and returns the result to the granted requester over a valid/ready response channel. Sits directly in front of the CDU command/data/response pins.

---
 rtl/cdu_req_arbiter_if.sv | 68 ++++++
 rtl/cdu_req_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_cdu_req_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cdu_req_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cdu_req_arbiter_if : requester, response and CDU pin bundle for the arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
interface cdu_req_arbiter_if #(
  parameter int DATA_W = 80,
  parameter int COMP_W = 8
);
  logic              req0_valid;
  logic              req0_ready;
  logic [1:0]        req0_cmd;
  logic [DATA_W-1:0] req0_data;
  logic [COMP_W-1:0] req0_comp;

  logic              req1_valid;
  logic              req1_ready;
  logic [1:0]        req1_cmd;
  logic [DATA_W-1:0] req1_data;
  logic [COMP_W-1:0] req1_comp;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [1:0]        rsp0_code;
  logic [COMP_W-1:0] rsp0_comp;
  logic [DATA_W-1:0] rsp0_data;

  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [1:0]        rsp1_code;
  logic [COMP_W-1:0] rsp1_comp;
  logic [DATA_W-1:0] rsp1_data;

  logic [1:0]        cdu_command;
  logic [DATA_W-1:0] cdu_data_in;
  logic [COMP_W-1:0] cdu_compressed_in;
  logic [COMP_W-1:0] cdu_compressed_out;
  logic [DATA_W-1:0] cdu_decompressed_out;
  logic [1:0]        cdu_response;

  logic              busy;

  modport slave (
    input  req0_valid, req0_cmd, req0_data, req0_comp,
    input  req1_valid, req1_cmd, req1_data, req1_comp,
    input  rsp0_ready, rsp1_ready,
    input  cdu_compressed_out, cdu_decompressed_out, cdu_response,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_code, rsp0_comp, rsp0_data,
    output rsp1_valid, rsp1_code, rsp1_comp, rsp1_data,
    output cdu_command, cdu_data_in, cdu_compressed_in,
    output busy
  );

  modport master (
    output req0_valid, req0_cmd, req0_data, req0_comp,
    output req1_valid, req1_cmd, req1_data, req1_comp,
    output rsp0_ready, rsp1_ready,
    output cdu_compressed_out, cdu_decompressed_out, cdu_response,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_code, rsp0_comp, rsp0_data,
    input  rsp1_valid, rsp1_code, rsp1_comp, rsp1_data,
    input  cdu_command, cdu_data_in, cdu_compressed_in,
    input  busy
  );
endinterface

`default_nettype wire

// File: rtl/cdu_req_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cdu_req_arbiter : round-robin sharing of one CDU between two requesters
// Revision: 1.0
// ----------------------------------------------------------------------------
module cdu_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int DATA_W         = 80,
  parameter int COMP_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  cdu_req_arbiter_if.slave bus
);

  localparam logic [1:0] CMD_COMP   = 2'b01;
  localparam logic [1:0] CMD_DECOMP = 2'b10;
  localparam logic [1:0] CODE_ERR   = 2'b11;
  localparam logic [7:0] TMO_LIM    = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_RETURN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [COMP_W-1:0] comp_q, comp_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        code_q, code_d;
  logic [COMP_W-1:0] rcomp_q, rcomp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              w_idle;
  logic              w_sel;
  logic              w_ready0;
  logic              w_ready1;
  logic              w_req_hs;
  logic              w_rsp_hs;
  logic [1:0]        w_sel_cmd;
  logic [DATA_W-1:0] w_sel_data;
  logic [COMP_W-1:0] w_sel_comp;
  logic              w_sel_legal;
  logic              w_rsp0_v;
  logic              w_rsp1_v;
  logic              w_drive_cdu;

  // Port 1 wins when it is the only requester, or when both ask and port 0 went last.
  assign w_idle   = (state_q == S_IDLE) && reset;
  assign w_sel    = bus.req1_valid && (!bus.req0_valid || !last_q);
  assign w_ready0 = w_idle && bus.req0_valid && !w_sel;
  assign w_ready1 = w_idle && w_sel;
  assign w_req_hs = w_ready0 || w_ready1;

  assign w_sel_cmd   = w_sel ? bus.req1_cmd  : bus.req0_cmd;
  assign w_sel_data  = w_sel ? bus.req1_data : bus.req0_data;
  assign w_sel_comp  = w_sel ? bus.req1_comp : bus.req0_comp;
  assign w_sel_legal = (w_sel_cmd == CMD_COMP) || (w_sel_cmd == CMD_DECOMP);

  assign w_rsp0_v = (state_q == S_RETURN) && !gnt_q;
  assign w_rsp1_v = (state_q == S_RETURN) &&  gnt_q;
  assign w_rsp_hs = (w_rsp0_v && bus.rsp0_ready) || (w_rsp1_v && bus.rsp1_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cmd_q   <= 2'b00;
      data_q  <= '0;
      comp_q  <= '0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
      code_q  <= 2'b00;
      rcomp_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      comp_q  <= comp_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      rcomp_q <= rcomp_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    comp_d  = comp_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    rcomp_d = rcomp_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (w_req_hs) begin
          cmd_d  = w_sel_cmd;
          data_d = w_sel_data;
          comp_d = w_sel_comp;
          gnt_d  = w_sel;
          if (w_sel_legal) begin
            state_d = S_ISSUE;
          end else begin
            // Illegal commands never reach the CDU.
            state_d = S_RETURN;
            code_d  = CODE_ERR;
            rcomp_d = '0;
            rdata_d = '0;
          end
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = 8'd1;
      end

      S_WAIT: begin
        if (bus.cdu_response != 2'b00) begin
          state_d = S_RETURN;
          cnt_d   = 8'd0;
          if (bus.cdu_response == cmd_q) begin
            code_d  = cmd_q;
            rcomp_d = (cmd_q == CMD_COMP)   ? bus.cdu_compressed_out   : '0;
            rdata_d = (cmd_q == CMD_DECOMP) ? bus.cdu_decompressed_out : '0;
          end else begin
            code_d  = CODE_ERR;
            rcomp_d = '0;
            rdata_d = '0;
          end
        end else if (cnt_q >= TMO_LIM) begin
          state_d = S_RETURN;
          cnt_d   = 8'd0;
          code_d  = CODE_ERR;
          rcomp_d = '0;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_RETURN: begin
        if (w_rsp_hs) begin
          state_d = S_IDLE;
          last_d  = gnt_q;
          code_d  = 2'b00;
          rcomp_d = '0;
          rdata_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Operands stay on the CDU pins for the whole issue/wait window.
  assign w_drive_cdu           = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign bus.cdu_command       = (state_q == S_ISSUE) ? cmd_q : 2'b00;
  assign bus.cdu_data_in       = w_drive_cdu ? data_q : '0;
  assign bus.cdu_compressed_in = w_drive_cdu ? comp_q : '0;

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;

  assign bus.rsp0_valid = w_rsp0_v;
  assign bus.rsp0_code  = w_rsp0_v ? code_q  : 2'b00;
  assign bus.rsp0_comp  = w_rsp0_v ? rcomp_q : '0;
  assign bus.rsp0_data  = w_rsp0_v ? rdata_q : '0;

  assign bus.rsp1_valid = w_rsp1_v;
  assign bus.rsp1_code  = w_rsp1_v ? code_q  : 2'b00;
  assign bus.rsp1_comp  = w_rsp1_v ? rcomp_q : '0;
  assign bus.rsp1_data  = w_rsp1_v ? rdata_q : '0;

  assign bus.busy = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_cdu_req_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cdu_req_arbiter : directed scoreboard bench for cdu_req_arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_cdu_req_arbiter;

  localparam int DW  = 80;
  localparam int CW  = 8;
  localparam int TMO = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cdu_req_arbiter_if #(.DATA_W(DW), .COMP_W(CW)) bus ();

  cdu_req_arbiter #(
    .TIMEOUT_CYCLES(TMO),
    .DATA_W        (DW),
    .COMP_W        (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int            port;
    logic [1:0]    code;
    logic [CW-1:0] comp;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input int port, input logic [1:0] cmd, input logic [1:0] resp,
                                 input logic [CW-1:0] cout, input logic [DW-1:0] dout);
    exp_t m;
    m.port = port;
    m.code = 2'b11;
    m.comp = '0;
    m.data = '0;
    if (((cmd == 2'b01) || (cmd == 2'b10)) && (resp == cmd)) begin
      m.code = resp;
      if (resp == 2'b01) m.comp = cout;
      else               m.data = dout;
    end
    return m;
  endfunction

  task automatic drive_req(input int port, input logic v, input logic [1:0] cmd,
                           input logic [DW-1:0] data, input logic [CW-1:0] comp);
    if (port == 1) begin
      bus.req1_valid = v; bus.req1_cmd = cmd; bus.req1_data = data; bus.req1_comp = comp;
    end else begin
      bus.req0_valid = v; bus.req0_cmd = cmd; bus.req0_data = data; bus.req0_comp = comp;
    end
  endtask

  task automatic check_rsp(input string tag, input exp_t e);
    if (e.port == 1) begin
      check({tag, "_valid"}, bus.rsp1_valid, 1);
      check({tag, "_other"}, bus.rsp0_valid, 0);
      check({tag, "_code"},  bus.rsp1_code,  e.code);
      check({tag, "_comp"},  bus.rsp1_comp,  e.comp);
      check({tag, "_data"},  bus.rsp1_data,  e.data);
    end else begin
      check({tag, "_valid"}, bus.rsp0_valid, 1);
      check({tag, "_other"}, bus.rsp1_valid, 0);
      check({tag, "_code"},  bus.rsp0_code,  e.code);
      check({tag, "_comp"},  bus.rsp0_comp,  e.comp);
      check({tag, "_data"},  bus.rsp0_data,  e.data);
    end
  endtask

  // Called at posedge+1 while the DUT is idle; the request handshakes at the next edge.
  // lat = WAIT cycle in which the CDU answers (or the timeout length when resp is 00).
  // hold = number of RETURN cycles with rsp_ready low.
  task automatic serve(input int port, input logic [1:0] cmd, input logic [DW-1:0] data,
                       input logic [CW-1:0] comp, input logic [1:0] resp, input int lat,
                       input logic [CW-1:0] cout, input logic [DW-1:0] dout, input int hold);
    exp_t e;
    logic legal;
    legal = (cmd == 2'b01) || (cmd == 2'b10);
    drive_req(port, 1'b1, cmd, data, comp);
    if (hold > 0) begin
      if (port == 1) bus.rsp1_ready = 1'b0; else bus.rsp0_ready = 1'b0;
    end
    #1;
    check("req_ready",       (port == 1) ? bus.req1_ready : bus.req0_ready, 1);
    check("req_ready_other", (port == 1) ? bus.req0_ready : bus.req1_ready, 0);
    sb.push_back(model(port, cmd, resp, cout, dout));
    tick();
    if (port == 1) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
    check("busy", bus.busy, 1);
    if (legal) begin
      check("cdu_cmd_issue", bus.cdu_command, cmd);
      check("cdu_data_in",   bus.cdu_data_in, data);
      check("cdu_comp_in",   bus.cdu_compressed_in, comp);
      for (int i = 1; i <= lat; i++) begin
        tick();
        if (i == 1) check("cdu_cmd_wait", bus.cdu_command, 0);
        check("rsp_early", bus.rsp0_valid | bus.rsp1_valid, 0);
        if ((i == lat) && (resp != 2'b00)) begin
          bus.cdu_response         = resp;
          bus.cdu_compressed_out   = cout;
          bus.cdu_decompressed_out = dout;
        end
      end
      tick();
      bus.cdu_response = 2'b00;
    end
    check("cdu_cmd_ret", bus.cdu_command, 0);
    check("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_rsp("rsp", e);
      if (hold > 0) begin
        if (port == 1) bus.req0_valid = 1'b1; else bus.req1_valid = 1'b1;
        #1;
        check("no_grant", bus.req0_ready | bus.req1_ready, 0);
        for (int h = 1; h < hold; h++) begin
          tick();
          check_rsp("rsp_hold", e);
          check("no_grant_hold", bus.req0_ready | bus.req1_ready, 0);
        end
      end
    end
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    tick();
    check("busy_after", bus.busy, 0);
    check("rsp_drop", bus.rsp0_valid | bus.rsp1_valid, 0);
  endtask

  initial begin
    drive_req(0, 1'b0, 2'b00, '0, '0);
    drive_req(1, 1'b0, 2'b00, '0, '0);
    bus.rsp0_ready           = 1'b1;
    bus.rsp1_ready           = 1'b1;
    bus.cdu_response         = 2'b00;
    bus.cdu_compressed_out   = '0;
    bus.cdu_decompressed_out = '0;

    // Reset state
    #12;
    check("rst_busy",    bus.busy, 0);
    check("rst_cmd",     bus.cdu_command, 0);
    check("rst_din",     bus.cdu_data_in, 0);
    check("rst_cin",     bus.cdu_compressed_in, 0);
    check("rst_rspv",    bus.rsp0_valid | bus.rsp1_valid, 0);
    check("rst_ready",   bus.req0_ready | bus.req1_ready, 0);
    tick();
    reset = 1'b1;
    tick();

    // Both valid from reset: port 0 first, then alternation
    drive_req(1, 1'b1, 2'b01, 80'hAAAA_BBBB_CCCC_DDDD_EEEE, 8'h00);
    serve(0, 2'b10, '0, 8'h3C, 2'b10, 1, 8'h00, 80'h0F0F_0F0F_0F0F_0F0F_0F0F, 0);
    serve(1, 2'b01, 80'hAAAA_BBBB_CCCC_DDDD_EEEE, 8'h00, 2'b01, 2, 8'hC3, '0, 0);
    drive_req(1, 1'b1, 2'b10, '0, 8'h44);
    serve(0, 2'b01, 80'h0000_0000_0000_0000_0001, 8'h00, 2'b01, 1, 8'h11, '0, 0);
    serve(1, 2'b10, '0, 8'h44, 2'b10, 3, 8'h00, 80'hDEAD_BEEF_0000_1234_5678, 0);

    // Single compress with a one-cycle CDU
    serve(0, 2'b01, 80'h1234_5678_9ABC_DEF0_1111, 8'h00, 2'b01, 1, 8'h5A, '0, 0);

    // CDU silent: timeout, then a late response is ignored
    serve(1, 2'b10, '0, 8'h77, 2'b00, TMO, 8'h00, '0, 0);
    bus.cdu_response         = 2'b10;
    bus.cdu_decompressed_out = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    tick();
    check("late_busy", bus.busy, 0);
    check("late_rspv", bus.rsp0_valid | bus.rsp1_valid, 0);
    bus.cdu_response = 2'b00;
    tick();
    check("late_busy2", bus.busy, 0);

    // Illegal command goes straight to an error response
    serve(0, 2'b11, 80'h5555, 8'h66, 2'b00, 0, 8'h00, '0, 0);

    // Mismatched CDU response with back-pressure; port 1 queued meanwhile
    drive_req(1, 1'b0, 2'b10, '0, 8'h21);
    serve(0, 2'b01, 80'h9999_8888_7777_6666_5555, 8'h00, 2'b10, 1, 8'h33, 80'h1234, 5);
    serve(1, 2'b10, '0, 8'h21, 2'b10, 2, 8'h00, 80'h0123_4567_89AB_CDEF_0011, 0);

    // Reset asserted in WAIT aborts the transaction
    drive_req(0, 1'b1, 2'b01, 80'h7777, 8'h00);
    tick();
    drive_req(0, 1'b0, 2'b01, 80'h7777, 8'h00);
    tick();
    check("pre_rst_busy", bus.busy, 1);
    drive_req(0, 1'b1, 2'b01, 80'h7777, 8'h00);
    drive_req(1, 1'b1, 2'b01, 80'h8888, 8'h00);
    reset = 1'b0;
    #1;
    check("mid_rst_busy",  bus.busy, 0);
    check("mid_rst_cmd",   bus.cdu_command, 0);
    check("mid_rst_rspv",  bus.rsp0_valid | bus.rsp1_valid, 0);
    check("mid_rst_ready", bus.req0_ready | bus.req1_ready, 0);
    check("mid_rst_din",   bus.cdu_data_in, 0);
    drive_req(0, 1'b0, 2'b00, '0, '0);
    drive_req(1, 1'b0, 2'b00, '0, '0);
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_rspv", bus.rsp0_valid | bus.rsp1_valid, 0);
    serve(0, 2'b01, 80'h2468_ACE0_1357_9BDF_0246, 8'h00, 2'b01, 3, 8'hA5, '0, 0);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
